// File: rtl/cursor_move_scheduler_if.sv
// Signal bundle shared by the game FSM, human buttons, CPU player and cursor block
// around the cursor move scheduler.
interface cursor_move_scheduler_if;
  logic       turn_valid;
  logic       turn_owner;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       ai_req;
  logic [3:0] ai_row;
  logic [3:0] ai_col;
  logic [3:0] cur_row;
  logic [3:0] cur_col;
  logic       mv_en;
  logic       mv_up;
  logic       mv_down;
  logic       mv_left;
  logic       mv_right;
  logic       ai_busy;
  logic       ai_done;

  modport master (
    output turn_valid, turn_owner, btn_up, btn_down, btn_left, btn_right,
           ai_req, ai_row, ai_col, cur_row, cur_col,
    input  mv_en, mv_up, mv_down, mv_left, mv_right, ai_busy, ai_done
  );

  modport slave (
    input  turn_valid, turn_owner, btn_up, btn_down, btn_left, btn_right,
           ai_req, ai_row, ai_col, cur_row, cur_col,
    output mv_en, mv_up, mv_down, mv_left, mv_right, ai_busy, ai_done
  );
endinterface

// File: rtl/cursor_move_scheduler.sv
// Arbitrates cursor moves between human buttons (press + auto-repeat) and the CPU target walk.
// Optional macro AI_DIAG_EN: CPU walk steps diagonally instead of row-then-column.
module cursor_move_scheduler #(
  parameter int TICK_DIV     = 1000000,
  parameter int REPEAT_START = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int MAX_INDEX    = 9
) (
  input logic                   clk,
  input logic                   reset,
  cursor_move_scheduler_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REPEAT_START + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_START);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_START - REPEAT_RATE);
  localparam logic [3:0]    MAX_IDX    = 4'(MAX_INDEX);

  typedef enum logic [2:0] {IDLE, HUMAN, AI_STEP, AI_WAIT, AI_DONE} state_e;

  // Direction vectors are packed as {up, down, left, right}.
  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_next;
  logic          rpt_arm_q, rpt_arm_d;
  logic [3:0]    btn_prev_q;
  logic          req_used_q, req_used_d;
  logic [3:0]    tgt_row_q, tgt_row_d, tgt_col_q, tgt_col_d;
  logic          mv_en_q, mv_en_d;
  logic [3:0]    mv_dir_q, mv_dir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick;
  logic [3:0]    btn, rose, cand, row_dir, col_dir, ai_dir;

  function automatic logic [3:0] cancelOpposing(input logic [3:0] dirs, input logic [3:0] held);
    logic [3:0] r;
    r = dirs;
    if (held[3] && held[2]) r[3:2] = 2'b00;
    if (held[1] && held[0]) r[1:0] = 2'b00;
    return r;
  endfunction

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign btn      = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
  assign rose     = btn & ~btn_prev_q;
  assign rpt_next = rpt_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      rpt_cnt_q  <= '0;
      rpt_arm_q  <= 1'b0;
      btn_prev_q <= '0;
      req_used_q <= 1'b0;
      tgt_row_q  <= '0;
      tgt_col_q  <= '0;
      mv_en_q    <= 1'b0;
      mv_dir_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_arm_q  <= rpt_arm_d;
      btn_prev_q <= btn;
      req_used_q <= req_used_d;
      tgt_row_q  <= tgt_row_d;
      tgt_col_q  <= tgt_col_d;
      mv_en_q    <= mv_en_d;
      mv_dir_q   <= mv_dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // One cell toward the latched target; row is preferred unless walking diagonally.
  always_comb begin
    row_dir = 4'b0000;
    col_dir = 4'b0000;
    if (tgt_row_q > bus.cur_row)      row_dir = 4'b0100;
    else if (tgt_row_q < bus.cur_row) row_dir = 4'b1000;
    if (tgt_col_q > bus.cur_col)      col_dir = 4'b0001;
    else if (tgt_col_q < bus.cur_col) col_dir = 4'b0010;
`ifdef AI_DIAG_EN
    ai_dir = row_dir | col_dir;
`else
    ai_dir = (row_dir != 4'b0000) ? row_dir : col_dir;
`endif
  end

  always_comb begin
    state_d    = state_q;
    rpt_cnt_d  = rpt_cnt_q;
    rpt_arm_d  = rpt_arm_q;
    req_used_d = bus.ai_req ? req_used_q : 1'b0;
    tgt_row_d  = tgt_row_q;
    tgt_col_d  = tgt_col_q;
    mv_en_d    = 1'b0;
    mv_dir_d   = 4'b0000;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cand       = 4'b0000;
    case (state_q)
      IDLE: begin
        rpt_arm_d = 1'b0;
        rpt_cnt_d = '0;
        if (bus.turn_valid && !bus.turn_owner) begin
          state_d = HUMAN;
        end else if (bus.turn_valid && bus.turn_owner && bus.ai_req && !req_used_q) begin
          tgt_row_d  = (bus.ai_row > MAX_IDX) ? MAX_IDX : bus.ai_row;
          tgt_col_d  = (bus.ai_col > MAX_IDX) ? MAX_IDX : bus.ai_col;
          busy_d     = 1'b1;
          req_used_d = 1'b1;
          state_d    = AI_STEP;
        end
      end
      HUMAN: begin
        if (!bus.turn_valid || bus.turn_owner) begin
          state_d   = IDLE;
          rpt_arm_d = 1'b0;
          rpt_cnt_d = '0;
        end else begin
          // Repeat arms only on a fresh press, so a button held across reset never auto-moves.
          if (rose != 4'b0000) begin
            cand      = rose;
            rpt_arm_d = 1'b1;
            rpt_cnt_d = '0;
          end else if (btn == 4'b0000) begin
            rpt_arm_d = 1'b0;
            rpt_cnt_d = '0;
          end else if (rpt_arm_q && tick) begin
            if (rpt_next == RPT_FIRE) begin
              cand      = btn;
              rpt_cnt_d = RPT_RELOAD;
            end else begin
              rpt_cnt_d = rpt_next;
            end
          end
          cand = cancelOpposing(cand, btn);
          if (cand != 4'b0000 && !mv_en_q) begin
            mv_en_d  = 1'b1;
            mv_dir_d = cand;
          end
        end
      end
      AI_STEP: begin
        if (!bus.turn_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tick) begin
          if (tgt_row_q == bus.cur_row && tgt_col_q == bus.cur_col) begin
            state_d = AI_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            mv_en_d  = 1'b1;
            mv_dir_d = ai_dir;
            state_d  = AI_WAIT;
          end
        end
      end
      AI_WAIT: begin
        if (!bus.turn_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = AI_STEP;
        end
      end
      AI_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mv_en    = mv_en_q;
  assign bus.mv_up    = mv_dir_q[3];
  assign bus.mv_down  = mv_dir_q[2];
  assign bus.mv_left  = mv_dir_q[1];
  assign bus.mv_right = mv_dir_q[0];
  assign bus.ai_busy  = busy_q;
  assign bus.ai_done  = done_q;

endmodule

// File: tb/tb_cursor_move_scheduler.sv
// Self-checking bench for cursor_move_scheduler: directed scenarios plus a randomized phase,
// all compared every cycle against a behavioural model and a clamping cursor model.
module tb_cursor_move_scheduler;

  localparam int TICK_DIV = 4;
  localparam int RS       = 8;
  localparam int RR       = 2;
  localparam int MAXI     = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cursor_move_scheduler_if bus();

  cursor_move_scheduler #(
    .TICK_DIV(TICK_DIV), .REPEAT_START(RS), .REPEAT_RATE(RR), .MAX_INDEX(MAXI)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Cursor block stand-in: applies strobes, saturating at the grid edges.
  logic [3:0] curRow, curCol;
  assign bus.cur_row = curRow;
  assign bus.cur_col = curCol;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      curRow <= 4'd0;
      curCol <= 4'd0;
    end else if (bus.mv_en) begin
      if (bus.mv_up && curRow != 4'd0)              curRow <= curRow - 4'd1;
      else if (bus.mv_down && curRow != 4'(MAXI))   curRow <= curRow + 4'd1;
      if (bus.mv_left && curCol != 4'd0)            curCol <= curCol - 4'd1;
      else if (bus.mv_right && curCol != 4'(MAXI))  curCol <= curCol + 4'd1;
    end
  end

  // Behavioural reference: mode 0 idle, 1 human, 2 walk, 3 settle, 4 finish.
  int         mode, heldTicks, tRow, tCol, dRow, dCol, modelStrobes;
  longint     cyc;
  logic [3:0] prevB, expDir, b, rose, cand, rowPart, colPart;
  logic       expEn, expBusy, expDone, armed, reqUsed, lastEn, tickNow;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mode = 0; heldTicks = 0; tRow = 0; tCol = 0; cyc = 0;
      prevB = 4'b0; expDir = 4'b0; expEn = 1'b0; expBusy = 1'b0; expDone = 1'b0;
      armed = 1'b0; reqUsed = 1'b0;
    end else begin
      b       = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
      tickNow = ((cyc % TICK_DIV) == TICK_DIV - 1);
      cyc++;
      rose    = b & ~prevB;
      prevB   = b;
      lastEn  = expEn;
      expEn   = 1'b0;
      expDir  = 4'b0;
      expDone = 1'b0;
      if (!bus.ai_req) reqUsed = 1'b0;
      case (mode)
        0: begin
          if (bus.turn_valid && !bus.turn_owner) mode = 1;
          else if (bus.turn_valid && bus.turn_owner && bus.ai_req && !reqUsed) begin
            tRow = (int'(bus.ai_row) > MAXI) ? MAXI : int'(bus.ai_row);
            tCol = (int'(bus.ai_col) > MAXI) ? MAXI : int'(bus.ai_col);
            expBusy = 1'b1;
            reqUsed = 1'b1;
            mode = 2;
          end
        end
        1: begin
          if (!bus.turn_valid || bus.turn_owner) begin
            mode = 0;
            armed = 1'b0;
          end else begin
            cand = 4'b0;
            if (rose != 4'b0) begin
              cand = rose; armed = 1'b1; heldTicks = 0;
            end else if (b == 4'b0) begin
              armed = 1'b0;
            end else if (armed && tickNow) begin
              heldTicks++;
              if (heldTicks >= RS && ((heldTicks - RS) % RR) == 0) cand = b;
            end
            if (b[3] && b[2]) cand[3:2] = 2'b00;
            if (b[1] && b[0]) cand[1:0] = 2'b00;
            if (cand != 4'b0 && !lastEn) begin
              expEn = 1'b1; expDir = cand;
            end
          end
        end
        2: begin
          if (!bus.turn_valid) begin
            mode = 0; expBusy = 1'b0;
          end else if (tickNow) begin
            dRow = tRow - int'(bus.cur_row);
            dCol = tCol - int'(bus.cur_col);
            if (dRow == 0 && dCol == 0) begin
              mode = 4; expDone = 1'b1; expBusy = 1'b0;
            end else begin
              rowPart = (dRow > 0) ? 4'b0100 : (dRow < 0) ? 4'b1000 : 4'b0000;
              colPart = (dCol > 0) ? 4'b0001 : (dCol < 0) ? 4'b0010 : 4'b0000;
`ifdef AI_DIAG_EN
              expDir = rowPart | colPart;
`else
              expDir = (rowPart != 4'b0) ? rowPart : colPart;
`endif
              expEn = 1'b1;
              mode = 3;
            end
          end
        end
        3: begin
          if (!bus.turn_valid) begin
            mode = 0; expBusy = 1'b0;
          end else mode = 2;
        end
        default: mode = 0;
      endcase
      if (expEn) modelStrobes++;
    end
  end

  // Sole owner of the check counters; literal checks are handed over through litSeq.
  int         errors = 0, checks = 0;
  int         dutStrobes = 0, dutDown = 0, dutRight = 0, dutDones = 0;
  int         litSeq = 0, litDone = 0, litAct, litReq;
  string      litName;
  logic       lastMvEn = 1'b0;
  logic [6:0] dutOut, expOut;

  always @(negedge clk) begin
    dutOut = {bus.mv_en, bus.mv_up, bus.mv_down, bus.mv_left, bus.mv_right, bus.ai_busy, bus.ai_done};
    expOut = {expEn, expDir, expBusy, expDone};
    checks++;
    if (dutOut !== expOut) begin
      errors++;
      $display("[TB] FAIL cycle_compare t=%0t actual=%b required=%b", $time, dutOut, expOut);
    end
    if (bus.mv_en === 1'b1) begin
      checks++;
      if (lastMvEn) begin
        errors++;
        $display("[TB] FAIL mv_en_back_to_back t=%0t actual=1 required=0", $time);
      end
      dutStrobes++;
      if (bus.mv_down)  dutDown++;
      if (bus.mv_right) dutRight++;
    end
    if (bus.ai_done === 1'b1) dutDones++;
    lastMvEn = (bus.mv_en === 1'b1);
    if (litSeq != litDone) begin
      checks++;
      if (litAct !== litReq) begin
        errors++;
        $display("[TB] FAIL %s actual=%0d required=%0d", litName, litAct, litReq);
      end
      litDone = litSeq;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int required);
    litName = name;
    litAct  = actual;
    litReq  = required;
    litSeq++;
    waitCycles(1);
  endtask

  task automatic applyStimulus(input logic tv, input logic own, input logic [3:0] btns,
                               input logic req, input logic [3:0] row, input logic [3:0] col);
    bus.turn_valid = tv;
    bus.turn_owner = own;
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = btns;
    bus.ai_req = req;
    bus.ai_row = row;
    bus.ai_col = col;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'd0);
    waitCycles(3);
    reset = 1'b0;
    waitCycles(1);
  endtask

  function automatic int outVec();
    return int'({bus.mv_en, bus.mv_up, bus.mv_down, bus.mv_left, bus.mv_right, bus.ai_busy, bus.ai_done});
  endfunction

  int  s0, m0, d0, r0, k0;
  bit  gotDone;
  logic [3:0] rb;
  logic rtv, rown, rreq;

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'd0);
    waitCycles(2);
    checkOutput("reset_outputs", outVec(), 0);
    reset = 1'b0;
    waitCycles(1);

    // Human: walk the cursor to column 3 with single presses.
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0, 4'd0, 4'd0);
    waitCycles(2);
    repeat (3) begin
      bus.btn_right = 1'b1; waitCycles(2);
      bus.btn_right = 1'b0; waitCycles(2);
    end
    checkOutput("col_after_three_presses", int'(curCol), 3);

    s0 = dutStrobes; m0 = modelStrobes;
    bus.btn_right = 1'b1;
    waitCycles(1);
    checkOutput("press_latency_right", outVec() >> 2, 5'b10001);
    waitCycles(24);
    bus.btn_right = 1'b0;
    waitCycles(3);
    checkOutput("single_press_strobes", dutStrobes - s0, 1);
    checkOutput("model_single_press", modelStrobes - m0, 1);
    checkOutput("col_after_hold", int'(curCol), 4);

    // Held button: press plus repeats at 8, 10, 12, 14 ticks.
    s0 = dutStrobes; m0 = modelStrobes; r0 = dutDown;
    bus.btn_down = 1'b1;
    waitCycles(58);
    bus.btn_down = 1'b0;
    waitCycles(4);
    checkOutput("repeat_strobes", dutStrobes - s0, 5);
    checkOutput("model_repeat_strobes", modelStrobes - m0, 5);
    checkOutput("repeat_down_count", dutDown - r0, 5);
    checkOutput("row_after_repeat", int'(curRow), 5);

    // Opposing vertical buttons cancel, horizontal still moves.
    {bus.btn_up, bus.btn_down, bus.btn_left} = 3'b111;
    waitCycles(1);
    checkOutput("opposing_cancel", outVec() >> 2, 5'b10010);
    {bus.btn_up, bus.btn_down, bus.btn_left} = 3'b000;
    waitCycles(3);

    // Reset mid-HUMAN with up held, then no move until a fresh press.
    bus.btn_up = 1'b1;
    waitCycles(3);
    #2 reset = 1'b1;
    #1 checkOutput("reset_mid_human", outVec(), 0);
    bus.turn_valid = 1'b0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(2);
    s0 = dutStrobes;
    bus.turn_valid = 1'b1;
    waitCycles(44);
    checkOutput("no_move_after_reset", dutStrobes - s0, 0);
    bus.btn_up = 1'b0;
    waitCycles(2);
    bus.btn_up = 1'b1;
    waitCycles(3);
    checkOutput("fresh_press_after_reset", dutStrobes - s0, 1);
    bus.btn_up = 1'b0;

    // CPU walk to (2,3) from (0,0).
    doReset();
    s0 = dutStrobes; d0 = dutDones; r0 = dutDown; k0 = dutRight;
    applyStimulus(1'b1, 1'b1, 4'b0, 1'b1, 4'd2, 4'd3);
    waitCycles(2);
    checkOutput("ai_busy_set", int'(bus.ai_busy), 1);
    gotDone = 1'b0;
    for (int i = 0; i < 200 && !gotDone; i++) begin
      waitCycles(1);
      if (dutDones != d0) gotDone = 1'b1;
    end
    checkOutput("ai_done_seen", int'(gotDone), 1);
`ifdef AI_DIAG_EN
    checkOutput("ai_step_count", dutStrobes - s0, 3);
`else
    checkOutput("ai_step_count", dutStrobes - s0, 5);
`endif
    checkOutput("ai_down_count", dutDown - r0, 2);
    checkOutput("ai_right_count", dutRight - k0, 3);
    checkOutput("ai_final_pos", int'(curRow) * 16 + int'(curCol), 2 * 16 + 3);
    waitCycles(20);
    checkOutput("held_req_ignored", int'(bus.ai_busy) + (dutDones - d0), 1);
    bus.ai_req = 1'b0;
    waitCycles(2);

    // Clamped target (12,15), abort after four steps.
    doReset();
    s0 = dutStrobes; d0 = dutDones;
    applyStimulus(1'b1, 1'b1, 4'b0, 1'b1, 4'd12, 4'd15);
    for (int i = 0; i < 200 && (dutStrobes - s0) < 4; i++) waitCycles(1);
    checkOutput("abort_four_steps_seen", dutStrobes - s0, 4);
    bus.turn_valid = 1'b0;
    waitCycles(6);
    checkOutput("abort_busy_low", int'(bus.ai_busy), 0);
    checkOutput("abort_no_done", dutDones - d0, 0);
    checkOutput("abort_no_more_strobes", dutStrobes - s0, 4);
`ifdef AI_DIAG_EN
    checkOutput("abort_pos", int'(curRow) * 16 + int'(curCol), 4 * 16 + 4);
`else
    checkOutput("abort_pos", int'(curRow) * 16 + int'(curCol), 4 * 16 + 0);
`endif

    // Clamped target walked to completion.
    doReset();
    d0 = dutDones;
    applyStimulus(1'b1, 1'b1, 4'b0, 1'b1, 4'd12, 4'd15);
    gotDone = 1'b0;
    for (int i = 0; i < 400 && !gotDone; i++) begin
      waitCycles(1);
      if (dutDones != d0) gotDone = 1'b1;
    end
    checkOutput("clamp_done_seen", int'(gotDone), 1);
    checkOutput("clamp_final_pos", int'(curRow) * 16 + int'(curCol), 9 * 16 + 9);

    // Randomized phase, checked by the per-cycle model compare.
    doReset();
    rtv = 1'b0; rown = 1'b0; rreq = 1'b0; rb = 4'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) rtv = ~rtv;
      if ($urandom_range(0, 59) == 0) rown = ~rown;
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 9) == 0) rb[j] = ~rb[j];
      if ($urandom_range(0, 11) == 0) begin
        rreq = ~rreq;
        if (rreq) begin
          bus.ai_row = 4'($urandom_range(0, 15));
          bus.ai_col = 4'($urandom_range(0, 15));
        end
      end
      bus.turn_valid = rtv;
      bus.turn_owner = rown;
      {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = rb;
      bus.ai_req = rreq;
      waitCycles(1);
    end

    waitCycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
